// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit.
//   Issues sequential word fetches to instruction memory. Responses return in
//   request order and land in a small in-order queue. A redirect flushes the
//   queue and restarts fetch. Responses to requests issued before the redirect
//   are counted as stale and dropped when they arrive.
//
// Build option:
//   IFU_BYPASS_EN - if defined, a non-stale response that arrives while the
//   queue is empty is presented on inst/inst_pc in the same cycle. If the
//   consumer takes it in that cycle, it is not pushed. If the macro is not
//   defined, every output comes from a register.
//
// Ports:
//   clock, reset               - clock, async active-high reset
//   imem_req/addr/gnt          - fetch request channel (addr word aligned)
//   imem_rvalid/rdata          - in-order fetch responses
//   redirect, redirect_pc      - flush pulse and restart address
//   inst_valid/inst/inst_pc    - queue head to consumer
//   inst_ready                 - consumer takes the head
//   q_count                    - queue occupancy
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [ADDR_W-1:0]          inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       data;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc, rsp_pc, restart_pc;
  logic [CW-1:0]     outstanding, stale, count;
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt;
  entry_t            mem [DEPTH];
  entry_t            head_q, head_nxt, rsp_entry;
  logic [CW:0]       inflight;
  logic              fire, rsp_fire, acc, byp, take_direct, push, pop;

  // Low address bits of the restart address carry no information.
  logic unused;
  assign unused = ^redirect_pc[1:0];

  assign restart_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign inflight   = {1'b0, count} + {1'b0, outstanding};
  // Reserving a queue slot for every in-flight request means the queue never overflows.
  assign imem_req   = !reset && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign fire       = imem_req && imem_gnt;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_fire   = imem_rvalid && (outstanding != '0);
  assign acc        = rsp_fire && (stale == '0) && !redirect;
  assign rsp_entry  = '{pc: rsp_pc, data: imem_rdata};

`ifdef IFU_BYPASS_EN
  assign byp = acc && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign take_direct = byp && inst_ready;
  assign pop         = (count != '0) && inst_ready && !redirect;
  assign push        = acc && !take_direct;
  assign rd_ptr_nxt  = rd_ptr + PW'(pop);

  // The head is held in its own register so the outputs keep their last values
  // when the queue runs empty.
  always_comb begin
    head_nxt = head_q;
    if (count - CW'(pop) != '0) head_nxt = mem[rd_ptr_nxt];
    else if (acc)               head_nxt = rsp_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      head_q      <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rsp_fire);
      if (redirect) begin
        fetch_pc <= restart_pc;
        rsp_pc   <= restart_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Everything still in flight after this cycle's response belongs to the old stream.
        stale    <= outstanding - CW'(rsp_fire);
      end else begin
        if (fire)                    fetch_pc <= fetch_pc + ADDR_W'(4);
        if (acc)                     rsp_pc   <= rsp_pc + ADDR_W'(4);
        if (rsp_fire && stale != '0) stale    <= stale - CW'(1);
        if (push)                    wr_ptr   <= wr_ptr + PW'(1);
        rd_ptr <= rd_ptr_nxt;
        count  <= count + CW'(push) - CW'(pop);
        head_q <= head_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rsp_entry;
  end

  assign q_count = count;

`ifdef IFU_BYPASS_EN
  assign inst_valid = (count != '0) || byp;
  assign inst       = byp ? imem_rdata : head_q.data;
  assign inst_pc    = byp ? rsp_pc : head_q.pc;
`else
  assign inst_valid = (count != '0);
  assign inst       = head_q.data;
  assign inst_pc    = head_q.pc;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch (DEPTH=4, RESET_PC=0x100),
// plus an 8-bit address instance for the wrap case. Memory model: in-order
// responder with 1-cycle latency, which can be held or driven manually.
module tb_ifu_prefetch;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [2:0]  q_count;

  logic        w_req, w_gnt, w_rvalid, w_redirect, w_inst_valid, w_ready;
  logic [7:0]  w_addr, w_redirect_pc, w_inst_pc;
  logic [31:0] w_rdata, w_inst;
  logic [2:0]  w_q_count;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] oq[$];
  bit          mem_hold = 1'b0;
  bit          mem_manual = 1'b0;

  always #5 clock = ~clock;

  ifu_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .q_count(q_count)
  );

  ifu_prefetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) dut_w (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(w_ready), .q_count(w_q_count)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record an accepted request, then drive the next in-order response.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    #1;
    f = imem_req & imem_gnt;
    a = imem_addr;
    @(posedge clock);
    #1;
    redirect = 1'b0;
    if (f) oq.push_back(a);
    if (!mem_manual) begin
      if (!mem_hold && oq.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(oq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    mem_hold = 1'b0;
    mem_manual = 1'b0;
    oq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 64'(inst_valid), 64'(1));
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [7:0]  wexp [4];
    int          n_items;
    logic [2:0]  max_q;
    wexp = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0; w_redirect = 1'b0;
    w_redirect_pc = 8'h0; w_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_req",    64'(imem_req),   64'(0));
    chk("rst_qcount", 64'(q_count),    64'(0));
    chk("rst_valid",  64'(inst_valid), 64'(0));
    chk("rst_inst",   64'(inst),       64'(0));
    chk("rst_pc",     64'(inst_pc),    64'(0));
    chk("rst_addr",   64'(imem_addr),  64'h100);
    chk("rst_waddr",  64'(w_addr),     64'hF8);

    // Wrap on an 8-bit address space: nothing returns, so four requests then stop.
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_req",  64'(w_req),  64'(1));
      chk("wrap_addr", 64'(w_addr), 64'(wexp[i]));
      tick();
    end
    chk("wrap_req_stop", 64'(w_req), 64'(0));

    // Streaming with the consumer always ready.
    do_reset();
    inst_ready = 1'b1;
    chk("first_req",  64'(imem_req),  64'(1));
    chk("first_addr", 64'(imem_addr), 64'h100);
    tick();
    chk("first_valid", 64'(inst_valid), 64'(BYP));
    exp_pc = 32'h100;
    n_items = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) begin
        chk("stream_pc",   64'(inst_pc), 64'(exp_pc));
        chk("stream_data", 64'(inst),    64'(data_of(exp_pc)));
        exp_pc += 32'h4;
        n_items++;
      end
      chk("stream_qcnt", 64'(q_count <= 3'd4), 64'(1));
      tick();
    end
    chk("stream_items", 64'(n_items), 64'(BYP ? 10 : 9));

    // Backpressure: consumer stalls for 10 cycles.
    inst_ready = 1'b0;
    max_q = 3'd0;
    repeat (10) begin
      tick();
      if (q_count > max_q) max_q = q_count;
    end
    chk("bp_qcount",  64'(q_count), 64'(4));
    chk("bp_maxq",    64'(max_q),   64'(4));
    chk("bp_req",     64'(imem_req), 64'(0));
    chk("bp_head_pc", 64'(inst_pc), 64'(exp_pc));

    // A response with nothing outstanding must change nothing.
    mem_manual = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    mem_manual = 1'b0;
    chk("proto_qcount", 64'(q_count), 64'(4));

    // Release: stream continues with no gap in addresses.
    inst_ready = 1'b1;
    n_items = 0;
    for (int i = 0; i < 8; i++) begin
      if (inst_valid) begin
        chk("rel_pc",   64'(inst_pc), 64'(exp_pc));
        chk("rel_data", 64'(inst),    64'(data_of(exp_pc)));
        exp_pc += 32'h4;
        n_items++;
      end
      tick();
    end
    chk("rel_items", 64'(n_items), 64'(8));

    // Redirect with three responses outstanding.
    do_reset();
    inst_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (3) tick();
    chk("redir_pre_req", 64'(imem_req), 64'(1));
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    chk("redir_req_low", 64'(imem_req), 64'(0));
    tick();
    chk("redir_addr",   64'(imem_addr), 64'h2000);
    chk("redir_qcount", 64'(q_count),   64'(0));
    mem_hold = 1'b0;
    wait_valid("redir");
    chk("redir_pc",   64'(inst_pc), 64'h2000);
    chk("redir_data", 64'(inst),    64'(data_of(32'h2000)));

    // Redirect, response and consumer-ready all in one cycle with one entry queued.
    do_reset();
    mem_hold = 1'b1;
    repeat (3) tick();
    mem_hold = 1'b0;
    repeat (2) tick();
    chk("sim_pre_qcount", 64'(q_count),     64'(1));
    chk("sim_pre_rvalid", 64'(imem_rvalid), 64'(1));
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    inst_ready = 1'b1;
    mem_hold = 1'b1;
    tick();
    chk("sim_qcount",  64'(q_count),    64'(0));
    chk("sim_valid",   64'(inst_valid), 64'(0));
    chk("sim_hold_pc", 64'(inst_pc),    64'h100);
    chk("sim_addr",    64'(imem_addr),  64'h3000);
    mem_hold = 1'b0;
    wait_valid("sim");
    chk("sim_pc", 64'(inst_pc), 64'h3000);

    // Response arriving at an empty queue: same cycle with bypass, else next cycle.
    do_reset();
    mem_manual = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h8C22_0004;
    #1;
    chk("byp_same_valid", 64'(inst_valid), 64'(BYP));
    chk("byp_same_inst",  64'(inst),       64'(BYP ? 32'h8C22_0004 : 32'h0));
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("byp_next_valid",  64'(inst_valid), 64'(1));
    chk("byp_next_inst",   64'(inst),       64'h8C22_0004);
    chk("byp_next_pc",     64'(inst_pc),    64'h100);
    chk("byp_next_qcount", 64'(q_count),    64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
